prio_arbiter: RTL and testbench

Parametrised N-way arbiter that turns a request vector into a registered one-hot grant plus encoded index. It extends the combinational lowest-index-first priority encoder with three additions: a runtime choice between fixed priority and round-robin, grant locking while the owner keeps requesting, and an optional hold limit that forces a handoff. It sits between N requesters and a single shared resource.

---
 rtl/arb_pkg.sv | 10 +
 rtl/prio_pick.sv | 44 ++++
 rtl/prio_arbiter.sv | 141 ++++++++++++++
 tb/tb_prio_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the priority arbiter.
//   arb_state_t : IDLE (no grant held) / BUSY (one owner holds the grant)
package arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/prio_pick.sv
// Combinational winner search: first set bit of mask_i at or above base_i,
// wrapping modulo N.
//   mask_i   : candidate vector
//   base_i   : index where the scan starts (0 = plain lowest-index-first)
//   onehot_o : winner as a one-hot vector (zero when mask_i is empty)
//   idx_o    : winner index (zero when mask_i is empty)
//   any_o    : mask_i has at least one bit set
module prio_pick #(
   parameter  int N    = 8,
   localparam int IDXW = $clog2(N)
) (
   input  logic [N-1:0]    mask_i,
   input  logic [IDXW-1:0] base_i,
   output logic [N-1:0]    onehot_o,
   output logic [IDXW-1:0] idx_o,
   output logic            any_o
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic           found;
   int             pos;

   // Rotating a doubled copy right by base puts the scan start at bit 0, so
   // a plain lowest-bit search handles the wrap; base is added back after.
   always_comb begin
      dbl      = {mask_i, mask_i} >> base_i;
      rot      = dbl[N-1:0];
      found    = 1'b0;
      pos      = 0;
      idx_o    = '0;
      any_o    = |mask_i;
      for (int i = 0; i < N; i++) begin
         if (rot[i] && !found) begin
            found = 1'b1;
            pos   = i + int'(base_i);
            if (pos >= N) pos = pos - N;
            idx_o = IDXW'(pos);
         end
      end
      onehot_o = any_o ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : '0;
   end

endmodule

// File: rtl/prio_arbiter.sv
// N-way arbiter with registered one-hot grant and encoded index.
// Fixed (lowest index first) or round-robin selection at runtime, grant
// locking while the owner keeps requesting, and an optional hold limit that
// hands the grant to another pending requester.
//   clk, areset_n : clock (rising edge), async active-low reset
//   mode_rr       : 1 = round-robin from ptr, 0 = fixed priority from index 0
//   req           : request vector
//   gnt           : registered one-hot grant (zero when idle)
//   gnt_idx       : index of the owner (zero when idle)
//   gnt_valid     : a grant is held
//   preempt       : pulse on the first cycle of a grant made by the hold limit
import arb_pkg::*;

module prio_arbiter #(
   parameter  int N        = 8,
   parameter  int MAX_HOLD = 0,
   localparam int IDXW     = $clog2(N)
) (
   input  logic            clk,
   input  logic            areset_n,
   input  logic            mode_rr,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic [IDXW-1:0] gnt_idx,
   output logic            gnt_valid,
   output logic            preempt
);

   localparam int HW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

   arb_state_t      state_q, state_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            pre_q, pre_d;

   logic [IDXW-1:0] base;
   logic [N-1:0]    oh_a, oh_b;
   logic [IDXW-1:0] ix_a, ix_b;
   logic            any_a, any_b;
   logic            limit;
   logic            grab, excl;
   logic [IDXW-1:0] win;

   assign base = mode_rr ? ptr_q : '0;

   // Normal pick over all requests.
   prio_pick #(.N(N)) u_pick_all (
      .mask_i   (req),
      .base_i   (base),
      .onehot_o (oh_a),
      .idx_o    (ix_a),
      .any_o    (any_a)
   );

   // Pick with the current owner masked out, used for hold-limit handoff.
   prio_pick #(.N(N)) u_pick_excl (
      .mask_i   (req & ~gnt_q),
      .base_i   (base),
      .onehot_o (oh_b),
      .idx_o    (ix_b),
      .any_o    (any_b)
   );

   assign limit = (MAX_HOLD != 0) && (hold_q == HW'(HOLD_LAST)) && any_b;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      pre_d   = 1'b0;
      grab    = 1'b0;
      excl    = 1'b0;
      win     = '0;

      case (state_q)
         IDLE: begin
            if (any_a) grab = 1'b1;
         end
         BUSY: begin
            if (!req[idx_q]) begin
               // Owner released: hand over directly, or go idle.
               if (any_a) begin
                  grab = 1'b1;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  idx_d   = '0;
                  hold_d  = '0;
               end
            end else if (limit) begin
               grab  = 1'b1;
               excl  = 1'b1;
               pre_d = 1'b1;
            end else if (hold_q != HW'(HOLD_LAST)) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (grab) begin
         win     = excl ? ix_b : ix_a;
         state_d = BUSY;
         gnt_d   = excl ? oh_b : oh_a;
         idx_d   = win;
         hold_d  = '0;
         // ptr advances in fixed mode as well so a later switch to
         // round-robin starts after the most recent owner.
         ptr_d   = (int'(win) == N - 1) ? '0 : win + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         hold_q  <= '0;
         gnt_q   <= '0;
         idx_q   <= '0;
         pre_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         pre_q   <= pre_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = (state_q == BUSY);
   assign preempt   = pre_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter (N=8, MAX_HOLD=4).
module tb_prio_arbiter;

   localparam int N    = 8;
   localparam int IDXW = 3;

   logic            clk = 1'b0;
   bit              clk_en = 1'b1;
   logic            areset_n;
   logic            mode_rr;
   logic [N-1:0]    req;
   logic [N-1:0]    gnt;
   logic [IDXW-1:0] gnt_idx;
   logic            gnt_valid;
   logic            preempt;

   int ncmp  = 0;
   int nfail = 0;

   prio_arbiter #(.N(N), .MAX_HOLD(4)) dut (
      .clk       (clk),
      .areset_n  (areset_n),
      .mode_rr   (mode_rr),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   always #5 if (clk_en) clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".gnt"},     32'(gnt),       32'h0);
      chk({tag, ".idx"},     32'(gnt_idx),   32'h0);
      chk({tag, ".valid"},   32'(gnt_valid), 32'h0);
      chk({tag, ".preempt"}, 32'(preempt),   32'h0);
   endtask

   initial begin
      areset_n = 1'b0;
      mode_rr  = 1'b0;
      req      = '0;
      tick();
      tick();
      chk_idle("reset");
      areset_n = 1'b1;
      tick();
      chk_idle("post_reset_idle");

      // Fixed priority: lowest index wins, then direct handoff.
      req = 8'b1010_0100;
      tick();
      chk("fix.gnt",     32'(gnt),       32'h04);
      chk("fix.idx",     32'(gnt_idx),   32'd2);
      chk("fix.valid",   32'(gnt_valid), 32'h1);
      chk("fix.preempt", 32'(preempt),   32'h0);
      req = 8'b1010_0000;
      tick();
      chk("handoff.gnt",   32'(gnt),       32'h20);
      chk("handoff.idx",   32'(gnt_idx),   32'd5);
      chk("handoff.valid", 32'(gnt_valid), 32'h1);
      req = '0;
      tick();
      chk_idle("release_idle");

      // Async reset mid-grant with the clock stopped.
      req = 8'hFF;
      tick();
      chk("pre_rst.idx",   32'(gnt_idx),   32'd0);
      chk("pre_rst.valid", 32'(gnt_valid), 32'h1);
      clk_en = 1'b0;
      #3;
      areset_n = 1'b0;
      #2;
      chk_idle("async_reset");
      req = '0;
      #2;
      areset_n = 1'b1;
      clk_en   = 1'b1;
      tick();
      chk_idle("after_async");

      // Round-robin with constant full request: 4 cycles per owner.
      mode_rr = 1'b1;
      req     = 8'hFF;
      for (int o = 0; o <= 8; o++) begin
         for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("rr.o%0d.c%0d.idx", o, c), 32'(gnt_idx), 32'(o % 8));
            chk($sformatf("rr.o%0d.c%0d.pre", o, c), 32'(preempt),
                (c == 0 && o > 0) ? 32'h1 : 32'h0);
         end
      end
      req = '0;
      tick();
      chk("rr_end.valid", 32'(gnt_valid), 32'h0);

      // Fixed mode hold limit: 0 and 1 alternate every 4 cycles.
      mode_rr = 1'b0;
      req     = 8'h03;
      for (int o = 0; o < 4; o++) begin
         for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("fxh.o%0d.c%0d.idx", o, c), 32'(gnt_idx), 32'(o % 2));
            chk($sformatf("fxh.o%0d.c%0d.pre", o, c), 32'(preempt),
                (c == 0 && o > 0) ? 32'h1 : 32'h0);
         end
      end
      req = '0;
      tick();
      chk("fxh_end.valid", 32'(gnt_valid), 32'h0);

      // Lone requester: no competitor, held indefinitely.
      req = 8'h10;
      for (int c = 0; c < 20; c++) begin
        tick();
        chk($sformatf("single.c%0d.idx", c), 32'(gnt_idx), 32'd4);
        chk($sformatf("single.c%0d.pre", c), 32'(preempt), 32'h0);
      end
      chk("single.gnt", 32'(gnt), 32'h10);

      // Round-robin: owner 6 drops while 1 rises in the same cycle.
      mode_rr = 1'b1;
      req     = 8'h40;
      tick();
      chk("sim.own6", 32'(gnt_idx), 32'd6);
      req = 8'h02;
      tick();
      chk("sim.idx1", 32'(gnt_idx), 32'd1);
      chk("sim.gnt",  32'(gnt),     32'h02);
      chk("sim.pre",  32'(preempt), 32'h0);
      req = '0;
      tick();
      chk("sim.idle", 32'(gnt_valid), 32'h0);
      // ptr must now be 2: with bits 1 and 2 requesting, 2 wins.
      req = 8'h06;
      tick();
      chk("sim.ptr2", 32'(gnt_idx), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
